rvc_fetch_aligner: RTL
======================

# rvc_fetch_aligner

Parametrised instruction-fetch aligner for the RV32IC front end. Sits between the I-cache read port and the decompressor/decoder. Accepts fixed-width fetch blocks, buffers them as halfwords and emits one aligned instruction per handshake: either a 16-bit RVC parcel or a 32-bit instruction, including 32-bit instructions that straddle two fetch blocks. Unlike the single-word aligner, it adds:

- valid/ready backpressure on both sides;
- configurable fetch width and buffer depth;
- redirect flush with halfword-granular start PC;
- per-instruction PC.

## Interface

Parameters:
- FETCH_BYTES, 4, bytes per fetch block; 4 or 8. FETCH_HW = FETCH_BYTES/2.
- BUF_HW, 4, halfword buffer depth; must be power of two and ≥ FETCH_HW+1.
- BYTE_SWAP, 1, 1 = reverse byte order within each 32-bit word of fetch_data before use (cache delivers big-endian words); 0 = use as-is.

Ports (clock/reset: one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  redirect; discards buffer and in-flight fetch.
- flush_pc  in  32  new PC on flush; bit 0 ignored.
- fetch_valid  in  1  fetch block present.
- fetch_ready  out  1  block accepted when fetch_valid && fetch_ready.
- fetch_data  in  8*FETCH_BYTES  fetch block, lowest halfword = lowest address.
- inst_valid  out  1  complete instruction at buffer head.
- inst_ready  in  1  downstream consumes when inst_valid && inst_ready.
- inst_o  out  32  instruction; compressed parcels zero-extended to 32 bits.
- inst_is_c  out  1  1 = inst_o[15:0] is an RVC parcel.
- inst_pc  out  32  byte address of inst_o.

## Operation

- Buffer: circular halfword FIFO, rd_ptr/wr_ptr log2(BUF_HW) bits, count 0..BUF_HW.
- Push: on fetch handshake, write FETCH_HW halfwords minus drop_cnt, in address order.
  - drop_cnt is nonzero only for the first block after flush: flush_pc[log2(FETCH_BYTES)-1:1].
  - drop_cnt then clears.
- Head decode: h0 = buffer[rd_ptr], h1 = buffer[rd_ptr+1].
  - If count ≥ 1 and h0[1:0] ≠ 2'b11, emit compressed: inst_valid=1, inst_o={16'h0,h0}, inst_is_c=1, pop 1.
  - Else if count ≥ 2, emit 32-bit: inst_o={h1,h0}, inst_is_c=0, pop 2.
  - Else inst_valid=0. This covers the straddling upper half not yet arrived.
- Halfword 16'h0000 is emitted as compressed (is_c=1). Illegal detection belongs to the decoder.
- inst_o, inst_is_c and inst_valid are combinational from buffer state only. They must not depend on inst_ready.
- fetch_ready = (BUF_HW − count ≥ FETCH_HW) && !flush. It uses the registered count only; there is no same-cycle pop credit.
- PC register: advances +2 (compressed) or +4 on each output handshake, modulo 2^32.
- Simultaneous push and pop in one cycle: count_next = count + pushed − popped. Both apply.
- Flush:
  - count, rd_ptr and wr_ptr go to 0; pc ← {flush_pc[31:1],1'b0}; drop_cnt is loaded.
  - A fetch or output handshake in the flush cycle is ignored: fetch_ready is 0, and the output pop is discarded.
- Reset:
  - count=0, pointers=0, pc=0, drop_cnt=0.
  - Outputs: inst_valid=0, inst_o=0, inst_is_c=0 (muxed to 0 when empty), inst_pc=0, fetch_ready=1.
  - Reset mid-operation discards all buffered halfwords.
  - rst has priority over flush.

## Timing

- Latency: a block accepted at edge t is visible at inst_* in cycle t+1. There is no fetch→inst combinational path.
- Throughput: one instruction per cycle while the buffer is non-empty and the head is complete.
  - With FETCH_BYTES=4 and all compressed code, the buffer fills and fetch_ready drops.
  - With all 32-bit aligned code, fetch and output run at 1/cycle steady state.
- Straddle: a 32-bit instruction at pc[1]=1 becomes valid the cycle after its second block is accepted.
- After flush at edge t: fetch_ready=1 in cycle t+1. The first instruction is valid no earlier than t+2.

## Structure

- Package rvc_pkg:
  - QUAD_32 = 2'b11;
  - function is_rvc(hw) returning hw[1:0] ≠ QUAD_32;
  - function bswap32;
  - localparam checks for FETCH_BYTES ∈ {4,8} and BUF_HW ≥ FETCH_HW+1.
- Sub-module rvc_hw_fifo: halfword storage with multi-halfword push (0..FETCH_HW), pop of 0/1/2, count and two-entry head read.
- Top: head decode, PC, drop logic, flush.

## Test plan

All with BYTE_SWAP=0, FETCH_BYTES=4 unless noted.

1. **Mixed stream.** Reset, then blocks 0x0513_4505 and 0x4581_0005 with inst_ready=1. Required outputs:
   - {0x00004505, c=1, pc 0x0};
   - {0x00050513, c=0, pc 0x2} (straddle, one cycle after block 2);
   - {0x00004581, c=1, pc 0x6}.
2. **Backpressure.** inst_ready=0 while feeding 0x4505_4505 blocks. Required response:
   - fetch_ready drops once count > 2;
   - the held inst_o/inst_pc stay stable;
   - releasing inst_ready drains with pc 0,2,4,6.
3. **Flush to odd halfword.** flush with flush_pc=0x102, then block 0x4505_1111. Required response:
   - the low halfword is dropped;
   - output {0x00004505, c=1, pc 0x102};
   - a handshake asserted in the flush cycle is ignored.
4. **Simultaneous push/pop.** Count held at 2 while popping a 32-bit instruction and pushing in the same cycle. Required: count stays 2, with no loss or duplication of halfwords.
5. **FETCH_BYTES=8, BUF_HW=8.** Block 0x0005_0513_4505_4505. Required outputs:
   - pc 0 c=1;
   - pc 2 c=1;
   - pc 4 {0x00050513} c=0.
6. **Reset mid-straddle.** rst asserted with one halfword buffered. Required next cycle: inst_valid=0, inst_pc=0, fetch_ready=1.

Source files
------------

// File: rtl/rvc_pkg.sv
// Shared RVC definitions for the fetch aligner: quadrant decode, byte swap and
// parameter sanity checks used at elaboration.
package rvc_pkg;

  localparam logic [1:0] QUAD_32 = 2'b11;

  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != QUAD_32;
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic bit fetch_bytes_ok(input int fb);
    return (fb == 4) || (fb == 8);
  endfunction

  // Buffer must hold a whole block plus the leftover half of a straddler.
  function automatic bit buf_hw_ok(input int fb, input int bh);
    return (bh >= fb / 2 + 1) && ((bh & (bh - 1)) == 0);
  endfunction

endpackage

// File: rtl/rvc_hw_fifo.sv
// Circular halfword FIFO: push 0..FETCH_HW halfwords, pop 0/1/2, with a
// two-entry head window for the instruction decoder.
module rvc_hw_fifo
  import rvc_pkg::*;
#(
  parameter int FETCH_HW = 2,
  parameter int BUF_HW   = 4,
  localparam int PW      = $clog2(BUF_HW),
  localparam int CW      = PW + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic [CW-1:0]                push_n,
  input  logic [FETCH_HW-1:0][15:0]    push_hw,
  input  logic [1:0]                   pop_n,
  output logic [CW-1:0]                count,
  output logic [15:0]                  head0,
  output logic [15:0]                  head1
);

  logic [BUF_HW-1:0][15:0] mem_q, mem_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    for (int i = 0; i < FETCH_HW; i++) begin
      if (CW'(i) < push_n) mem_d[wr_ptr_q + PW'(i)] = push_hw[i];
    end
    wr_ptr_d = wr_ptr_q + PW'(push_n);
    rd_ptr_d = rd_ptr_q + PW'(pop_n);
    count_d  = count_q + push_n - CW'(pop_n);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only trusted when count says so.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign count = count_q;
  assign head0 = mem_q[rd_ptr_q];
  assign head1 = mem_q[rd_ptr_q + PW'(1)];

endmodule

// File: rtl/rvc_fetch_aligner.sv
// RV32IC fetch aligner: buffers fetch blocks as halfwords and emits one
// aligned 16/32-bit instruction with its PC per output handshake.
module rvc_fetch_aligner
  import rvc_pkg::*;
#(
  parameter int FETCH_BYTES = 4,
  parameter int BUF_HW      = 4,
  parameter bit BYTE_SWAP   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [31:0]              flush_pc,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [8*FETCH_BYTES-1:0] fetch_data,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_o,
  output logic                     inst_is_c,
  output logic [31:0]              inst_pc
);

  localparam int FETCH_HW = FETCH_BYTES / 2;
  localparam int PW       = $clog2(BUF_HW);
  localparam int CW       = PW + 1;
  localparam int DW       = $clog2(FETCH_HW);

  if (!fetch_bytes_ok(FETCH_BYTES) || !buf_hw_ok(FETCH_BYTES, BUF_HW)) begin : g_cfg_err
    $error("rvc_fetch_aligner: unsupported FETCH_BYTES/BUF_HW");
  end

  logic [31:0]               pc_q, pc_d;
  logic [DW-1:0]             drop_q, drop_d;
  logic [FETCH_HW-1:0][15:0] blk_hw, push_hw;
  logic [CW-1:0]             push_n, count;
  logic [1:0]                pop_n, pop_len;
  logic [15:0]               h0, h1;
  logic                      fetch_fire, inst_fire;
  logic                      unused_pc0;

  assign unused_pc0 = flush_pc[0];

  always_comb begin
    blk_hw = '0;
    for (int w = 0; w < FETCH_BYTES / 4; w++) begin
      logic [31:0] word;
      word = fetch_data[32*w +: 32];
      if (BYTE_SWAP) word = bswap32(word);
      blk_hw[2*w]   = word[15:0];
      blk_hw[2*w+1] = word[31:16];
    end
  end

  // Leading halfwords below a mid-block redirect target are shifted out.
  assign push_hw = blk_hw >> {drop_q, 4'd0};

  // Registered count only; a pop in this cycle does not free space early.
  assign fetch_ready = (({1'b0, count} + (CW+1)'(FETCH_HW)) <= (CW+1)'(BUF_HW)) && !flush;
  assign fetch_fire  = fetch_valid && fetch_ready;
  assign push_n      = fetch_fire ? (CW'(FETCH_HW) - CW'(drop_q)) : '0;

  rvc_hw_fifo #(.FETCH_HW(FETCH_HW), .BUF_HW(BUF_HW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .push_n  (push_n),
    .push_hw (push_hw),
    .pop_n   (pop_n),
    .count   (count),
    .head0   (h0),
    .head1   (h1)
  );

  always_comb begin
    inst_valid = 1'b0;
    inst_o     = '0;
    inst_is_c  = 1'b0;
    pop_len    = 2'd0;
    if ((count != '0) && is_rvc(h0)) begin
      inst_valid = 1'b1;
      inst_o     = {16'h0, h0};
      inst_is_c  = 1'b1;
      pop_len    = 2'd1;
    end else if (count >= CW'(2)) begin
      inst_valid = 1'b1;
      inst_o     = {h1, h0};
      pop_len    = 2'd2;
    end
  end

  assign inst_fire = inst_valid && inst_ready && !flush;
  assign pop_n     = inst_fire ? pop_len : 2'd0;

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (flush) begin
      pc_d   = {flush_pc[31:1], 1'b0};
      drop_d = flush_pc[DW:1];
    end else begin
      if (inst_fire)  pc_d   = pc_q + (inst_is_c ? 32'd2 : 32'd4);
      if (fetch_fire) drop_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  assign inst_pc = pc_q;

endmodule
